// File: rtl/wb_pkg.sv
// Shared write-back definitions: opcode constants, the opcode class decode,
// the commit FSM state type and the queued-result entry layout. The ALU and
// decoder import the same package, so opcode values are defined only here.
package wb_pkg;

  // Field widths inside a queued entry. They are the largest widths any
  // wb_commit instance may use (DATA_W <= 64, ADDR_W <= 32). Narrower
  // instances zero-extend on the way in and slice on the way out.
  localparam int WB_MAX_DATA_W = 64;
  localparam int WB_MAX_ADDR_W = 32;
  localparam int OP_W          = 5;

  localparam logic [OP_W-1:0] OP_NOP = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB = 5'd2;
  localparam logic [OP_W-1:0] OP_AND = 5'd3;
  localparam logic [OP_W-1:0] OP_OR  = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR = 5'd5;
  localparam logic [OP_W-1:0] OP_SHL = 5'd6;
  localparam logic [OP_W-1:0] OP_JMP = 5'd7;
  localparam logic [OP_W-1:0] OP_BNZ = 5'd8;
  localparam logic [OP_W-1:0] OP_SHR = 5'd9;
  localparam logic [OP_W-1:0] OP_GP  = 5'd10;

  typedef enum logic [1:0] {
    CLS_DROP,
    CLS_WRITE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_e;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } wb_state_e;

  typedef struct packed {
    logic [OP_W-1:0]          op;
    logic [WB_MAX_ADDR_W-1:0] rd;
    logic [WB_MAX_ADDR_W-1:0] br;
    logic [WB_MAX_DATA_W-1:0] data;
  } wb_entry_t;

  // Map an opcode to what the commit stage has to do with it.
  function automatic op_class_e classify_op(input logic [OP_W-1:0] op);
    op_class_e cls;
    case (op)
      OP_NOP:                         cls = CLS_DROP;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR, OP_GP:  cls = CLS_WRITE;
      OP_JMP, OP_BNZ:                 cls = CLS_BRANCH;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry in-order result buffer for the commit stage. Clear wins over
// push and pop in the same cycle so a flush also drops anything arriving
// alongside it. Pushes when full and pops when empty are ignored.
module wb_fifo
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  wb_entry_t  wr_entry,
  output wb_entry_t  head,
  output wb_entry_t  next,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  wb_entry_t mem [2];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      push_ok;
  logic      pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign next    = mem[~rd_ptr];

  // Storage, pointers and occupancy; clear empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Write-back / commit stage. Buffers ALU results in a two-entry FIFO and
// retires the head in order: register writes (held until the register
// file is ready), dropped NOPs, sticky illegal-opcode reporting and taken
// branches, which redirect fetch and flush everything younger.
// Optional feature: define WB_COMMIT_FWD_EN to add the fwd_addr / fwd_hit /
// fwd_data lookup of queued writes (youngest matching entry wins).
module wb_commit
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
`ifdef WB_COMMIT_FWD_EN
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        OpCode,
  input  logic [ADDR_W-1:0] RdOut,
  input  logic [ADDR_W-1:0] branchResult,
  input  logic [DATA_W-1:0] AluResult,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              illegal_op
);

  wb_state_e state_q;
  wb_state_e state_d;
  wb_entry_t wr_entry;
  wb_entry_t head;
  wb_entry_t next_e;
  op_class_e head_cls;
  logic [1:0] count;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      clear;
  logic      set_illegal;
  logic      illegal_q;
  logic      unused_bits;

  // in_ready depends only on registered state, so a pop in the same cycle
  // never lets a new entry slip into a full buffer.
  assign in_ready    = !full && (state_q == ST_RUN);
  assign push        = in_valid && in_ready;
  assign head_cls    = classify_op(head.op);
  assign illegal_op  = illegal_q;
  assign unused_bits = ^{head, next_e, count};

  // Widen the incoming result into the shared entry layout.
  always_comb begin
    wr_entry      = '0;
    wr_entry.op   = OpCode;
    wr_entry.rd   = WB_MAX_ADDR_W'(RdOut);
    wr_entry.br   = WB_MAX_ADDR_W'(branchResult);
    wr_entry.data = WB_MAX_DATA_W'(AluResult);
  end

  wb_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .wr_entry (wr_entry),
    .head     (head),
    .next     (next_e),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Commit state register: FLUSH lasts exactly one cycle after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
  end

  // Retire decision for the head entry plus all commit-side outputs.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    clear          = 1'b0;
    set_illegal    = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      ST_RUN: begin
        if (!empty) begin
          case (head_cls)
            CLS_WRITE: begin
              rf_we    = 1'b1;
              rf_waddr = head.rd[ADDR_W-1:0];
              rf_wdata = head.data[DATA_W-1:0];
              pop      = rf_ready;
            end
            CLS_BRANCH: begin
              pop = 1'b1;
              if ((head.op == OP_JMP) || (head.br[ADDR_W-1:0] != '0)) begin
                redirect_valid = 1'b1;
                redirect_pc    = head.br[ADDR_W-1:0];
                clear          = 1'b1;
                state_d        = ST_FLUSH;
              end
            end
            CLS_ILLEGAL: begin
              pop         = 1'b1;
              set_illegal = 1'b1;
            end
            default: pop = 1'b1;
          endcase
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

`ifdef WB_COMMIT_FWD_EN
  // Forward the youngest queued write whose destination matches fwd_addr.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if ((count == 2'd2) && (classify_op(next_e.op) == CLS_WRITE) &&
        (next_e.rd[ADDR_W-1:0] == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = next_e.data[DATA_W-1:0];
    end else if ((count != 2'd0) && (head_cls == CLS_WRITE) &&
                 (head.rd[ADDR_W-1:0] == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = head.data[DATA_W-1:0];
    end
  end
`endif

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result/data width.
REQ-002 SHALL have parameter ADDR_W, default 7, meaning register-address and branch-target width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  ALU result present.
REQ-006 SHALL have port in_ready  output  1  result accepted when in_valid & in_ready at clk edge.
REQ-007 SHALL have port OpCode  input  5  opcode passed through by the ALU.
REQ-008 SHALL have port RdOut  input  ADDR_W  destination register.
REQ-009 SHALL have port branchResult  input  ADDR_W  branch target; 0 means not taken.
REQ-010 SHALL have port AluResult  input  DATA_W  write data.
REQ-011 SHALL have port rf_we  output  1  register-file write strobe; rf_waddr  output  ADDR_W; rf_wdata  output  DATA_W.
REQ-012 SHALL have port rf_ready  input  1  register file accepts the write this cycle.
REQ-013 SHALL have port redirect_valid  output  1  one-cycle fetch redirect; redirect_pc  output  ADDR_W  target.
REQ-014 SHALL have port illegal_op  output  1  sticky undefined-opcode flag.

Function
REQ-015 SHALL buffer accepted results in a 2-entry in-order FIFO; in_ready = !full & state != FLUSH.
REQ-016 SHALL classify head entry: WRITE for opcodes 1,2,3,4,5,6,9,10; BRANCH for 7,8; DROP for 0; ILLEGAL for 11-31.
REQ-017 SHALL drive rf_we=1, rf_waddr=RdOut, rf_wdata=AluResult from registered head when head is WRITE; pop only when rf_we & rf_ready.
REQ-018 SHALL hold rf_we/rf_waddr/rf_wdata stable while rf_ready=0.
REQ-019 SHALL give latency: result accepted at edge N appears on rf_we no earlier than cycle N+1 (empty FIFO, rf_ready=1: exactly N+1).
REQ-020 SHALL pop DROP entries in one cycle with no side effect; ILLEGAL entries pop in one cycle and set illegal_op.
REQ-021 SHALL on BRANCH head: opcode 7 always taken; opcode 8 taken iff branchResult != 0; not-taken pops like DROP.
REQ-022 SHALL on taken branch: pulse redirect_valid=1 one cycle with redirect_pc=branchResult, pop branch, discard all younger FIFO entries, enter FLUSH.
REQ-023 SHALL implement states RUN (normal) and FLUSH (one cycle, in_ready=0, inputs ignored, FIFO empty) -> RUN unconditionally.
REQ-024 SHALL, when full and head pops same cycle, not accept a new entry that cycle (no pass-through).
REQ-025 SHALL, on simultaneous pop and push with one entry, keep ordering with occupancy unchanged.
REQ-026 SHALL keep illegal_op set until reset.

Reset
REQ-027 SHALL on rst: FIFO empty, state RUN, in_ready=1 after release, rf_we=0, rf_waddr=0, rf_wdata=0, redirect_valid=0, redirect_pc=0, illegal_op=0.
REQ-028 SHALL abandon any pending write or redirect when rst asserts mid-operation; no strobe after release until new input.

Configuration
REQ-029 SHALL, with macro WB_COMMIT_FWD_EN defined, add ports fwd_addr input ADDR_W, fwd_hit output 1, fwd_data output DATA_W: combinational match of fwd_addr against WRITE entries in FIFO, youngest wins.
REQ-030 SHALL, without WB_COMMIT_FWD_EN, omit those ports and all match logic.

Structure
REQ-031 SHALL place opcode constants (OP_NOP..OP_GP), state enum, and FIFO-entry struct in shared package wb_pkg, reused by the ALU and decoder.
REQ-032 SHALL implement the FIFO as sub-module wb_fifo (depth 2, push/pop/clear, full/empty).

Verification
REQ-033 Push op5 Rd=3 data=0x0000_0007, rf_ready=1 -> next cycle rf_we=1 addr=3 data=7, FIFO empty after.
REQ-034 rf_ready=0, push three op2 results -> third stalled (in_ready=0); release rf_ready -> writes in order, one per cycle.
REQ-035 Push op7 branchResult=0x12 then op5 Rd=4 -> redirect_valid one cycle pc=0x12, op5 never written, in_ready=0 one cycle.
REQ-036 Push op8 branchResult=0 -> no redirect, no write; op8 branchResult=0x05 -> redirect pc=0x05.
REQ-037 Push op 15 -> illegal_op=1 and stays; rst mid-stall with full FIFO -> all outputs zero, no stale write after release.
REQ-038 With WB_COMMIT_FWD_EN, two queued writes to Rd=9 (data 1 then 2), fwd_addr=9 -> fwd_hit=1, fwd_data=2.
